// File: rtl/timer_multi_ccp.sv
// timer_multi_ccp: one prescaled counter shared by NUM_CH compare/capture
// channels, with double-buffered period/compare values, registered PWM
// outputs and sticky write-1-to-clear event flags.
module timer_multi_ccp #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PSC_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [1:0]              mode_i,
  input  logic [PSC_W-1:0]        psc_i,
  input  logic [CNT_W-1:0]        period_i,
  input  logic [NUM_CH*CNT_W-1:0] cmp_i,
  input  logic [NUM_CH-1:0]       cap_mode_i,
  input  logic [NUM_CH-1:0]       cap_edge_i,
  input  logic [NUM_CH-1:0]       cap_in_i,
  input  logic [NUM_CH-1:0]       pwm_inv_i,
  input  logic [NUM_CH:0]         irq_en_i,
  input  logic [NUM_CH:0]         flag_clr_i,
  output logic [CNT_W-1:0]        cnt_o,
  output logic                    dir_o,
  output logic                    running_o,
  output logic [NUM_CH*CNT_W-1:0] cap_o,
  output logic [NUM_CH-1:0]       pwm_o,
  output logic [NUM_CH:0]         flag_o,
  output logic                    irq_o
);

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_UPDOWN  = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  // Run control: idle, counting, or locked out after a one-shot completes.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LOCK = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PSC_W-1:0] PSC_ONE = {{(PSC_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             start;
  logic             tick;
  logic             upd;
  logic [PSC_W-1:0] psc_q;
  logic [CNT_W-1:0] cnt_q, cnt_nx, cnt_init;
  logic             dir_q, dir_nx, dir_init;
  logic [CNT_W-1:0] per_sh_q;
  logic [CNT_W-1:0] cmp_sh_q [NUM_CH];
  logic [CNT_W-1:0] cap_q [NUM_CH];
  logic [NUM_CH-1:0] cap_prev_q;
  logic [NUM_CH-1:0] edge_det;
  logic [NUM_CH-1:0] cap_hit;
  logic [NUM_CH-1:0] match;
  logic [NUM_CH-1:0] pwm_raw_q, pwm_raw_d;
  logic [NUM_CH:0]   flag_q, flag_set;
  mode_e             mode;

  assign mode      = mode_e'(mode_i);
  assign running_o = (state_q == ST_RUN);
  assign tick      = running_o & en_i & (psc_q == psc_i);
  assign cnt_init  = (mode == MODE_DOWN) ? period_i : '0;
  assign dir_init  = (mode == MODE_DOWN);

  // Run-control state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Start/stop/one-shot lockout decisions; the lockout only clears via en_i=0.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          state_d = ST_RUN;
          start   = 1'b1;
        end
      end
      ST_RUN: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (tick && upd && (mode == MODE_ONESHOT)) begin
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next counter value, direction and update event for the current mode.
  always_comb begin
    cnt_nx = cnt_q;
    dir_nx = dir_q;
    upd    = 1'b0;
    case (mode)
      MODE_DOWN: begin
        dir_nx = 1'b1;
        if (cnt_q == '0) begin
          cnt_nx = period_i;
          upd    = 1'b1;
        end else begin
          cnt_nx = cnt_q - CNT_ONE;
        end
      end
      MODE_UPDOWN: begin
        if (per_sh_q == '0) begin
          cnt_nx = '0;
          dir_nx = 1'b0;
          upd    = 1'b1;
        end else if (!dir_q && (cnt_q >= per_sh_q)) begin
          cnt_nx = cnt_q - CNT_ONE;
          dir_nx = 1'b1;
        end else if (!dir_q) begin
          cnt_nx = cnt_q + CNT_ONE;
          if ((cnt_q + CNT_ONE) >= per_sh_q) begin
            dir_nx = 1'b1;
          end
        end else if (cnt_q <= CNT_ONE) begin
          cnt_nx = '0;
          dir_nx = 1'b0;
          upd    = 1'b1;
        end else begin
          cnt_nx = cnt_q - CNT_ONE;
        end
      end
      default: begin
        dir_nx = 1'b0;
        if (cnt_q >= per_sh_q) begin
          cnt_nx = '0;
          upd    = 1'b1;
        end else begin
          cnt_nx = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  // Prescaler, counter and shadow registers; shadows reload on start and update events.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      psc_q    <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      per_sh_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cmp_sh_q[i] <= '0;
      end
    end else if (start) begin
      psc_q    <= '0;
      cnt_q    <= cnt_init;
      dir_q    <= dir_init;
      per_sh_q <= period_i;
      for (int i = 0; i < NUM_CH; i++) begin
        cmp_sh_q[i] <= cmp_i[i*CNT_W +: CNT_W];
      end
    end else if (running_o && en_i) begin
      psc_q <= tick ? '0 : (psc_q + PSC_ONE);
      if (tick) begin
        cnt_q <= cnt_nx;
        dir_q <= dir_nx;
        if (upd) begin
          per_sh_q <= period_i;
          for (int i = 0; i < NUM_CH; i++) begin
            cmp_sh_q[i] <= cmp_i[i*CNT_W +: CNT_W];
          end
        end
      end
    end else begin
      psc_q <= '0;
    end
  end

  // Per-channel edge detection, compare matches and raw PWM level.
  always_comb begin
    edge_det  = '0;
    cap_hit   = '0;
    match     = '0;
    pwm_raw_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      edge_det[i]  = cap_edge_i[i] ? (cap_prev_q[i] & ~cap_in_i[i])
                                   : (~cap_prev_q[i] & cap_in_i[i]);
      cap_hit[i]   = running_o & cap_mode_i[i] & edge_det[i];
      match[i]     = tick & ~cap_mode_i[i] & (cnt_nx == cmp_sh_q[i]);
      pwm_raw_d[i] = ~cap_mode_i[i] & (cnt_q < cmp_sh_q[i]);
    end
    flag_set = {tick & upd, cap_hit | match};
  end

  // Capture registers, previous input samples and registered PWM level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cap_prev_q <= '0;
      pwm_raw_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cap_q[i] <= '0;
      end
    end else begin
      cap_prev_q <= cap_in_i;
      pwm_raw_q  <= pwm_raw_d;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap_hit[i]) begin
          cap_q[i] <= cnt_q;
        end
      end
    end
  end

  // Sticky flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flag_q <= '0;
    end else begin
      flag_q <= (flag_q & ~flag_clr_i) | flag_set;
    end
  end

  // Flatten the capture registers onto the output bus.
  always_comb begin
    cap_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cap_o[i*CNT_W +: CNT_W] = cap_q[i];
    end
  end

  assign cnt_o  = cnt_q;
  assign dir_o  = dir_q;
  assign pwm_o  = pwm_raw_q ^ pwm_inv_i;
  assign flag_o = flag_q;
  assign irq_o  = |(flag_q & irq_en_i);

endmodule

// File: tb/tb_timer_multi_ccp.sv
// tb_timer_multi_ccp: scoreboard bench for timer_multi_ccp. A reference model
// describes the counter as a position within the current period and pushes the
// expected state each clock; a monitor pops and compares on the falling edge.
`timescale 1ns/1ps
module tb_timer_multi_ccp;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int PSC_W  = 16;
  localparam int WIDE   = NUM_CH*CNT_W;

  logic                    clk_i      = 1'b0;
  logic                    rst_i      = 1'b1;
  logic                    en_i       = 1'b0;
  logic [1:0]              mode_i     = '0;
  logic [PSC_W-1:0]        psc_i      = '0;
  logic [CNT_W-1:0]        period_i   = '0;
  logic [WIDE-1:0]         cmp_i      = '0;
  logic [NUM_CH-1:0]       cap_mode_i = '0;
  logic [NUM_CH-1:0]       cap_edge_i = '0;
  logic [NUM_CH-1:0]       cap_in_i   = '0;
  logic [NUM_CH-1:0]       pwm_inv_i  = '0;
  logic [NUM_CH:0]         irq_en_i   = '0;
  logic [NUM_CH:0]         flag_clr_i = '0;
  logic [CNT_W-1:0]        cnt_o;
  logic                    dir_o;
  logic                    running_o;
  logic [WIDE-1:0]         cap_o;
  logic [NUM_CH-1:0]       pwm_o;
  logic [NUM_CH:0]         flag_o;
  logic                    irq_o;

  timer_multi_ccp #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .mode_i(mode_i), .psc_i(psc_i),
    .period_i(period_i), .cmp_i(cmp_i), .cap_mode_i(cap_mode_i),
    .cap_edge_i(cap_edge_i), .cap_in_i(cap_in_i), .pwm_inv_i(pwm_inv_i),
    .irq_en_i(irq_en_i), .flag_clr_i(flag_clr_i), .cnt_o(cnt_o), .dir_o(dir_o),
    .running_o(running_o), .cap_o(cap_o), .pwm_o(pwm_o), .flag_o(flag_o),
    .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [CNT_W-1:0]  cnt;
    logic              dir;
    logic              run;
    logic [NUM_CH:0]   flag;
    logic [NUM_CH-1:0] raw;
    logic [WIDE-1:0]   cap;
  } exp_t;

  exp_t exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: position in period rather than a counter register.
  logic              m_run, m_lock, m_dir;
  logic [CNT_W-1:0]  m_cnt, m_per;
  logic [CNT_W-1:0]  m_cmp [NUM_CH];
  logic [CNT_W-1:0]  m_cap [NUM_CH];
  logic [NUM_CH:0]   m_flag;
  logic [NUM_CH-1:0] m_raw, m_prev;
  longint unsigned   m_t;
  longint unsigned   m_n;

  task automatic checkOutput(input string name, input logic [WIDE-1:0] act,
                             input logic [WIDE-1:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic longint unsigned period_len(input logic [1:0] mode,
                                                 input logic [CNT_W-1:0] per);
    longint unsigned lp;
    lp = per;
    if (mode == 2'b10) return (lp == 0) ? 1 : 2*lp;
    return lp + 1;
  endfunction

  function automatic logic [CNT_W-1:0] value_at(input logic [1:0] mode,
                                                input logic [CNT_W-1:0] per,
                                                input longint unsigned t);
    longint unsigned lp;
    lp = per;
    case (mode)
      2'b01:   return CNT_W'(lp - t);
      2'b10:   return (t <= lp) ? CNT_W'(t) : CNT_W'(2*lp - t);
      default: return CNT_W'(t);
    endcase
  endfunction

  function automatic logic dir_at(input logic [1:0] mode, input logic [CNT_W-1:0] per,
                                  input longint unsigned t);
    longint unsigned lp;
    lp = per;
    if (mode == 2'b01) return 1'b1;
    if (mode == 2'b10) return (lp != 0) && (t >= lp);
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_run = 0; m_lock = 0; m_dir = 0; m_cnt = '0; m_per = '0;
    m_flag = '0; m_raw = '0; m_prev = '0; m_t = 0; m_n = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_cmp[i] = '0;
      m_cap[i] = '0;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.cnt = m_cnt; e.dir = m_dir; e.run = m_run; e.flag = m_flag; e.raw = m_raw;
    e.cap = '0;
    for (int i = 0; i < NUM_CH; i++) e.cap[i*CNT_W +: CNT_W] = m_cap[i];
    exp_q.push_back(e);
  endtask

  // Reference model: advances once per clock, or resets immediately on reset.
  always @(posedge clk_i or posedge rst_i) begin
    logic [NUM_CH-1:0] raw_n;
    logic [NUM_CH:0]   set;
    logic [CNT_W-1:0]  new_per, new_cnt;
    logic              wrap, edge_seen;
    if (rst_i) begin
      model_reset();
      exp_q.delete();
      push_expected();
    end else begin
      set = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        raw_n[i] = !cap_mode_i[i] && (m_cnt < m_cmp[i]);
        edge_seen = cap_edge_i[i] ? (m_prev[i] && !cap_in_i[i]) : (!m_prev[i] && cap_in_i[i]);
        if (m_run && cap_mode_i[i] && edge_seen) begin
          m_cap[i] = m_cnt;
          set[i] = 1'b1;
        end
        m_prev[i] = cap_in_i[i];
      end
      if (!en_i) begin
        m_run = 0;
        m_lock = 0;
      end else if (!m_run) begin
        if (!m_lock) begin
          m_run = 1; m_t = 0; m_n = 0; m_per = period_i;
          for (int i = 0; i < NUM_CH; i++) m_cmp[i] = cmp_i[i*CNT_W +: CNT_W];
          m_cnt = value_at(mode_i, m_per, 0);
          m_dir = dir_at(mode_i, m_per, 0);
        end
      end else begin
        m_n++;
        if ((m_n % (longint'(psc_i) + 1)) == 0) begin
          wrap = (m_t + 1) >= period_len(mode_i, m_per);
          new_per = wrap ? period_i : m_per;
          m_t = wrap ? 0 : m_t + 1;
          new_cnt = value_at(mode_i, new_per, m_t);
          for (int i = 0; i < NUM_CH; i++)
            if (!cap_mode_i[i] && new_cnt == m_cmp[i]) set[i] = 1'b1;
          if (wrap) begin
            m_per = new_per;
            for (int i = 0; i < NUM_CH; i++) m_cmp[i] = cmp_i[i*CNT_W +: CNT_W];
            set[NUM_CH] = 1'b1;
            if (mode_i == 2'b11) begin
              m_run = 0;
              m_lock = 1;
            end
          end
          m_cnt = new_cnt;
          m_dir = dir_at(mode_i, m_per, m_t);
        end
      end
      m_flag = (m_flag & ~flag_clr_i) | set;
      m_raw = raw_n;
      push_expected();
    end
  end

  // Monitor: compares the DUT against the oldest queued expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("cnt", cnt_o, e.cnt);
      checkOutput("dir", dir_o, e.dir);
      checkOutput("running", running_o, e.run);
      checkOutput("flag", flag_o, e.flag);
      checkOutput("pwm", pwm_o, e.raw ^ pwm_inv_i);
      checkOutput("cap", cap_o, e.cap);
      checkOutput("irq", irq_o, |(e.flag & irq_en_i));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input int psc, input int per,
                               input logic [WIDE-1:0] cmp, input logic [NUM_CH-1:0] cmode,
                               input logic [NUM_CH-1:0] cedge, input logic [NUM_CH-1:0] inv,
                               input logic [NUM_CH:0] ien);
    mode_i = mode; psc_i = PSC_W'(psc); period_i = CNT_W'(per); cmp_i = cmp;
    cap_mode_i = cmode; cap_edge_i = cedge; pwm_inv_i = inv; irq_en_i = ien;
  endtask

  function automatic logic [WIDE-1:0] rand_cmp(input int hi);
    logic [WIDE-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, hi));
    return v;
  endfunction

  task automatic wait_cnt(input int value, input string name);
    for (int k = 0; k < 300 && cnt_o != CNT_W'(value); k++) cycles(1);
    checkOutput(name, cnt_o, value);
  endtask

  task automatic clear_flags();
    flag_clr_i = '1;
    cycles(1);
    flag_clr_i = '0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDE-1:0] cmp_v;
    cycles(3);
    rst_i = 1'b0;

    // Up-count PWM, then a compare change mid-period that waits for the wrap.
    cmp_v = '0;
    cmp_v[0 +: CNT_W] = 3;
    applyStimulus(2'b00, 0, 9, cmp_v, '0, '0, '0, '1);
    en_i = 1;
    cycles(25);
    cmp_v[0 +: CNT_W] = 7;
    cmp_i = cmp_v;
    cycles(30);
    en_i = 0;
    cycles(3);

    // Up-down with a divide-by-two prescaler.
    applyStimulus(2'b10, 1, 4, rand_cmp(6), '0, '0, 4'b0101, '1);
    clear_flags();
    en_i = 1;
    cycles(40);
    en_i = 0;
    cycles(2);

    // One-shot: stays locked out while enabled, restarts after en toggles.
    applyStimulus(2'b11, 0, 5, rand_cmp(7), '0, '0, '0, '1);
    en_i = 1;
    cycles(15);
    checkOutput("oneshot_stopped", running_o, 0);
    en_i = 0;
    cycles(1);
    en_i = 1;
    cycles(10);
    en_i = 0;
    cycles(2);

    // Capture on channel 1, rising edge, with a coincident clear.
    applyStimulus(2'b00, 0, 100, rand_cmp(50), 4'b0010, 4'b0000, '0, '1);
    clear_flags();
    en_i = 1;
    wait_cnt(17, "cnt17_reached");
    cap_in_i[1] = 1;
    cycles(1);
    checkOutput("cap1_value", cap_o[1*CNT_W +: CNT_W], 17);
    checkOutput("cap1_flag", flag_o[1], 1);
    cap_in_i[1] = 0;
    cycles(1);
    cap_in_i[1] = 1;
    flag_clr_i[1] = 1;
    cycles(1);
    flag_clr_i = '0;
    checkOutput("cap1_set_wins", flag_o[1], 1);
    en_i = 0;
    cycles(2);

    // Randomized runs across all modes.
    for (int r = 0; r < 12; r++) begin
      en_i = 0;
      applyStimulus(2'($urandom_range(0, 3)), $urandom_range(0, 2), $urandom_range(0, 10),
                    rand_cmp(13), NUM_CH'($urandom), NUM_CH'($urandom),
                    NUM_CH'($urandom), (NUM_CH+1)'($urandom));
      cycles(2);
      en_i = 1;
      for (int c = 0; c < 80; c++) begin
        flag_clr_i = ($urandom_range(0, 7) == 0) ? (NUM_CH+1)'($urandom) : '0;
        if ($urandom_range(0, 3) == 0) cap_in_i = NUM_CH'($urandom);
        if ($urandom_range(0, 9) == 0) period_i = CNT_W'($urandom_range(0, 10));
        if ($urandom_range(0, 9) == 0) cmp_i = rand_cmp(13);
        en_i = ($urandom_range(0, 39) != 0);
        cycles(1);
      end
      flag_clr_i = '0;
    end
    en_i = 0;
    cycles(2);

    // Asynchronous reset in the middle of a count.
    applyStimulus(2'b00, 0, 20, rand_cmp(20), '0, '0, 4'b1001, '1);
    en_i = 1;
    wait_cnt(6, "cnt6_reached");
    #1 rst_i = 1;
    #1;
    checkOutput("rst_cnt", cnt_o, 0);
    checkOutput("rst_running", running_o, 0);
    checkOutput("rst_dir", dir_o, 0);
    checkOutput("rst_flag", flag_o, 0);
    checkOutput("rst_irq", irq_o, 0);
    checkOutput("rst_pwm", pwm_o, pwm_inv_i);
    checkOutput("rst_cap", cap_o, 0);
    cycles(2);
    rst_i = 0;
    cycles(15);
    en_i = 0;
    cycles(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/timer_multi_ccp.md
Name: timer_multi_ccp

Overview:
Next-generation general-purpose timer with NUM_CH independent compare/capture channels sharing one prescaled counter. It supports up, down, up-down (centre-aligned) and one-shot counting. Period and compare values are double-buffered so updates are glitch-free. It also provides per-channel PWM or input capture, and sticky interrupt flags with write-1-to-clear. It sits under the peripheral register file; all control inputs are register-file outputs, and capture inputs arrive already synchronised.

Parameters:
NUM_CH, 4, number of compare/capture channels (1..8)
CNT_W, 32, counter/compare/capture width
PSC_W, 16, prescaler width

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-high
en_i  in  1  run enable; 0 stops the counter and clears running_o
mode_i  in  2  00 up, 01 down, 10 up-down, 11 one-shot up
psc_i  in  PSC_W  prescaler divisor minus 1 (0 = tick every clock)
period_i  in  CNT_W  period value P (shadowed)
cmp_i  in  NUM_CH*CNT_W  compare values, channel i at [i*CNT_W +: CNT_W] (shadowed)
cap_mode_i  in  NUM_CH  1 = channel is capture, 0 = compare/PWM
cap_edge_i  in  NUM_CH  capture edge: 0 rising, 1 falling
cap_in_i  in  NUM_CH  capture inputs (synchronised)
pwm_inv_i  in  NUM_CH  PWM output inversion
irq_en_i  in  NUM_CH+1  interrupt enables; bit NUM_CH = update event
flag_clr_i  in  NUM_CH+1  one-cycle write-1-to-clear strobes
cnt_o  out  CNT_W  counter value
dir_o  out  1  0 counting up, 1 counting down
running_o  out  1  counter active
cap_o  out  NUM_CH*CNT_W  captured values
pwm_o  out  NUM_CH  PWM outputs
flag_o  out  NUM_CH+1  sticky flags; bit i = channel event, bit NUM_CH = update event
irq_o  out  1  OR of (flag_o & irq_en_i)

Behaviour:
- Reset values: cnt_o, cap_o, flag_o, prescaler and shadows all 0; running_o=0; dir_o=0; irq_o=0; pwm_o=pwm_inv_i (inactive level).
- Start:
  - Condition: en_i=1 while running_o=0 and no one-shot lockout.
  - Action next clock: running_o=1; period and compare shadows load from period_i/cmp_i; prescaler=0.
  - Initial state: cnt=P and dir=1 in down mode; otherwise cnt=0 and dir=0.
- Stop: en_i=0 forces running_o=0 next clock. cnt_o holds its value and the prescaler clears. A later start restarts from the initial value.
- Tick: asserted when running and the prescaler equals psc_i. The prescaler then wraps to 0. Without a tick the counter holds.
- Counter on tick:
  - Up: 0..P, then wraps to 0.
  - Down: P..0, then reloads P.
  - Up-down: 0 up to P with dir=0; at P, dir=1; counts down to 0; at 0, dir=0. Neither P nor 0 is repeated.
  - One-shot: like up; at the wrap the counter goes to 0, running_o=0, and a lockout is set. The lockout clears only when en_i=0.
- Update event: set on the tick that wraps (up/one-shot), reloads (down), or reaches 0 from 1 (up-down). On this event shadows reload from period_i/cmp_i and flag[NUM_CH] is set.
- P=0: the counter stays 0, and every tick is an update event.
- Compare (cap_mode_i[i]=0):
  - Match event when a tick makes the next cnt equal cmp_sh[i]; flag[i] sets on the same edge as cnt_o.
  - pwm_o[i] = (cnt_o < cmp_sh[i]) XOR pwm_inv_i[i], registered, so it lags cnt_o by one clock.
  - cmp_sh=0 gives constant inactive; cmp_sh>P gives constant active.
- Capture (cap_mode_i[i]=1):
  - Edge detect uses a previous-sample register, reset to 0.
  - On the selected edge while running_o=1: cap_o[i] <= cnt_o; flag[i] is set.
  - pwm_o[i] is held at pwm_inv_i[i].
  - Edges while stopped are ignored but still update the previous sample.
- Flags: sticky; flag_clr_i clears the bit next clock. If a set and a clear hit the same bit in the same cycle, the set wins.
- irq_o: combinational from registered flag_o and irq_en_i.
- Mode or cap_mode changes while running are legal and take effect on the next tick; the bench does not check transients.
- Reset asserted mid-operation returns every output to its reset value immediately, without waiting for a clock.

Test Plan:
- Up PWM: psc=0, P=9, cmp0=3, inv=0 -> period of 10 clocks; pwm_o[0] high for 3 clocks; flag[0] sets when cnt_o=3; flag[4] sets when cnt_o wraps 9->0.
- Up-down with psc=1, P=4 -> cnt sequence 0,1,2,3,4,3,2,1,0, each held for 2 clocks; dir_o=1 after 4; update flag only at 0.
- Shadowing: change cmp0 from 3 to 7 mid-period with P=9 -> PWM width stays 3 until the next wrap, then becomes 7.
- One-shot with P=5 -> counts 0..5, then cnt_o=0 and running_o=0; holding en_i=1 does not restart; toggling en_i 0->1 restarts.
- Capture: ch1 capture, rising edge; cap_in_i rises while cnt_o=17 -> cap_o[1]=17 and flag[1]=1. Simultaneous flag_clr_i[1] with a new edge -> flag stays 1.
- Async reset mid-count at cnt_o=6 -> all outputs reset without a clock edge; after reset release, en_i=1 starts from 0.
